// File: rtl/exec_pkg.sv
// Shared definitions for the multicycle execution unit: op codes, FSM states and latency constants.
package exec_pkg;

    localparam logic [3:0] OP_PASSA = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_NOTA  = 4'd6;
    localparam logic [3:0] OP_INCA  = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_ROR   = 4'd11;
    localparam logic [3:0] OP_MULT  = 4'd12;
    localparam logic [3:0] OP_DIV   = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_MUL   = 3'd2,
        ST_DIV   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int LAT_ALU = 32'sd1;

    function automatic int lat_muldiv(input int width);
        return width + 32'sd1;
    endfunction

endpackage

// File: rtl/exec_shifter.sv
// Bit-serial shifter: holds the operand and moves it one bit per step until the count runs out.
module exec_shifter
    import exec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       kind,
    input  logic [WIDTH-1:0] load_data,
    input  logic [SHW-1:0]   load_count,
    output logic [WIDTH-1:0] shifted,
    output logic             last
);

    logic [WIDTH-1:0] data_r;
    logic [SHW-1:0]   count_r;
    logic [1:0]       kind_r;

    // one-bit move of the held word; kind follows the low bits of the shift op codes
    always_comb begin
        shifted = data_r;
        case (kind_r)
            2'd0:    shifted = {data_r[WIDTH-2:0], 1'b0};
            2'd1:    shifted = {1'b0, data_r[WIDTH-1:1]};
            2'd2:    shifted = {data_r[WIDTH-1], data_r[WIDTH-1:1]};
            2'd3:    shifted = {data_r[0], data_r[WIDTH-1:1]};
            default: shifted = data_r;
        endcase
    end

    assign last = (count_r == SHW'(1));

    // operand, remaining count and shift kind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {WIDTH{1'b0}};
            count_r <= {SHW{1'b0}};
            kind_r  <= 2'd0;
        end else if (load) begin
            data_r  <= load_data;
            count_r <= load_count;
            kind_r  <= kind;
        end else if (step) begin
            data_r  <= shifted;
            count_r <= count_r - SHW'(1);
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Multicycle execution unit with start/done handshake: single-cycle ALU, bit-serial shifts and,
// when EXEC_MULDIV_EN is defined, iterative signed multiply/divide.
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [SHW-1:0]   shamt,
    input  logic             shamt_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             div_zero,
    output logic             illegal
);

    state_e           state_r, state_s;
    logic             accept_s, sh_step_s, sh_last_s;
    logic [WIDTH-1:0] sh_out_s, alu_res_s, fin_res_s;
    logic [SHW-1:0]   amount_s;
    logic             alu_ovf_s, fin_ovf_s, fin_ill_s;
    logic             eq_s, gt_s, lt_s, eq_c_r, gt_c_r, lt_c_r, fin_eq_s, fin_gt_s, fin_lt_s;
    logic             is_shift_s;

    assign amount_s   = shamt_sel ? src_b[SHW-1:0] : shamt;
    assign is_shift_s = (op[3:2] == 2'b10);
    assign eq_s       = (src_a == src_b);
    assign gt_s       = ($signed(src_a) > $signed(src_b));
    assign lt_s       = ($signed(src_a) < $signed(src_b));

    exec_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
        .clk        (clk),
        .rst_n      (reset),
        .load       (accept_s),
        .step       (sh_step_s),
        .kind       (op[1:0]),
        .load_data  (src_a),
        .load_count (amount_s),
        .shifted    (sh_out_s),
        .last       (sh_last_s)
    );

    // single-cycle ALU straight from the ports, used only on the accept cycle
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
        case (op)
            OP_PASSA: alu_res_s = src_a;
            OP_ADD: begin
                alu_res_s = src_a + src_b;
                alu_ovf_s = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (alu_res_s[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = src_a - src_b;
                alu_ovf_s = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (alu_res_s[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND:  alu_res_s = src_a & src_b;
            OP_OR:   alu_res_s = src_a | src_b;
            OP_XOR:  alu_res_s = src_a ^ src_b;
            OP_NOTA: alu_res_s = ~src_a;
            OP_INCA: begin
                alu_res_s = src_a + WIDTH'(1);
                alu_ovf_s = ~src_a[WIDTH-1] & alu_res_s[WIDTH-1];
            end
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

`ifdef EXEC_MULDIV_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]     md_hi_r, mul_sum_s, div_rs_s, div_hi_s;
    logic [WIDTH-1:0]   md_lo_r, md_den_r, mul_lo_s, div_lo_s, abs_a_s, abs_b_s, quo_s, rem_s;
    logic [CW-1:0]      md_cnt_r;
    logic               md_qneg_r, md_rneg_r, div_ge_s, md_last_s;
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;
    logic [WIDTH-1:0]   fin_hi_s;
    logic               fin_hi_we_s, fin_dz_s;

    assign abs_a_s = src_a[WIDTH-1] ? -src_a : src_a;
    assign abs_b_s = src_b[WIDTH-1] ? -src_b : src_b;
    assign md_last_s = (md_cnt_r == CW'(1));

    // one iteration of shift-add multiply and of restoring divide on magnitudes
    always_comb begin
        mul_sum_s  = md_hi_r + (md_lo_r[0] ? {1'b0, md_den_r} : {(WIDTH+1){1'b0}});
        mul_lo_s   = {mul_sum_s[0], md_lo_r[WIDTH-1:1]};
        prod_s     = {mul_sum_s[WIDTH:1], mul_lo_s};
        prod_fix_s = md_qneg_r ? -prod_s : prod_s;
        div_rs_s   = {md_hi_r[WIDTH-1:0], md_lo_r[WIDTH-1]};
        div_ge_s   = (div_rs_s >= {1'b0, md_den_r});
        div_hi_s   = div_ge_s ? (div_rs_s - {1'b0, md_den_r}) : div_rs_s;
        div_lo_s   = {md_lo_r[WIDTH-2:0], div_ge_s};
        quo_s      = md_qneg_r ? -div_lo_s : div_lo_s;
        rem_s      = md_rneg_r ? -div_hi_s[WIDTH-1:0] : div_hi_s[WIDTH-1:0];
    end

    // multiply/divide working registers; signs are restored at completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_hi_r   <= {(WIDTH+1){1'b0}};
            md_lo_r   <= {WIDTH{1'b0}};
            md_den_r  <= {WIDTH{1'b0}};
            md_cnt_r  <= {CW{1'b0}};
            md_qneg_r <= 1'b0;
            md_rneg_r <= 1'b0;
        end else if (accept_s) begin
            md_hi_r   <= {(WIDTH+1){1'b0}};
            md_lo_r   <= abs_a_s;
            md_den_r  <= abs_b_s;
            md_cnt_r  <= CW'(WIDTH);
            md_qneg_r <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
            md_rneg_r <= src_a[WIDTH-1];
        end else if (state_r == ST_MUL) begin
            md_hi_r  <= {1'b0, mul_sum_s[WIDTH:1]};
            md_lo_r  <= mul_lo_s;
            md_cnt_r <= md_cnt_r - CW'(1);
        end else if (state_r == ST_DIV) begin
            md_hi_r  <= div_hi_s;
            md_lo_r  <= div_lo_s;
            md_cnt_r <= md_cnt_r - CW'(1);
        end
    end
`endif

    // next state and the values to publish on entry to DONE
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        sh_step_s = 1'b0;
        fin_res_s = {WIDTH{1'b0}};
        fin_ovf_s = 1'b0;
        fin_ill_s = 1'b0;
        fin_eq_s  = eq_c_r;
        fin_gt_s  = gt_c_r;
        fin_lt_s  = lt_c_r;
`ifdef EXEC_MULDIV_EN
        fin_hi_s    = hi_out;
        fin_hi_we_s = 1'b0;
        fin_dz_s    = 1'b0;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    fin_eq_s = eq_s;
                    fin_gt_s = gt_s;
                    fin_lt_s = lt_s;
                    if (is_shift_s) begin
                        if (amount_s != {SHW{1'b0}}) begin
                            state_s = ST_SHIFT;
                        end else begin
                            state_s   = ST_DONE;
                            fin_res_s = src_a;
                        end
                    end
`ifdef EXEC_MULDIV_EN
                    else if (op == OP_MULT) begin
                        state_s = ST_MUL;
                    end else if (op == OP_DIV) begin
                        if (src_b != {WIDTH{1'b0}}) begin
                            state_s = ST_DIV;
                        end else begin
                            state_s  = ST_DONE;
                            fin_dz_s = 1'b1;
                        end
                    end
`endif
                    else begin
                        state_s   = ST_DONE;
                        fin_res_s = alu_res_s;
                        fin_ovf_s = alu_ovf_s;
                        fin_ill_s = (op[3:2] == 2'b11);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sh_step_s = 1'b1;
                if (sh_last_s) begin
                    state_s   = ST_DONE;
                    fin_res_s = sh_out_s;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
`ifdef EXEC_MULDIV_EN
            ST_MUL: begin
                if (md_last_s) begin
                    state_s     = ST_DONE;
                    fin_res_s   = prod_fix_s[WIDTH-1:0];
                    fin_hi_s    = prod_fix_s[2*WIDTH-1:WIDTH];
                    fin_hi_we_s = 1'b1;
                end else begin
                    state_s = ST_MUL;
                end
            end
            ST_DIV: begin
                if (md_last_s) begin
                    state_s     = ST_DONE;
                    fin_res_s   = quo_s;
                    fin_hi_s    = rem_s;
                    fin_hi_we_s = 1'b1;
                end else begin
                    state_s = ST_DIV;
                end
            end
`endif
            default: state_s = ST_IDLE;
        endcase
    end

    // state register and compare flags captured at launch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            eq_c_r  <= 1'b0;
            gt_c_r  <= 1'b0;
            lt_c_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                eq_c_r <= eq_s;
                gt_c_r <= gt_s;
                lt_c_r <= lt_s;
            end
        end
    end

    // registered handshake and outputs; results only move on entry to DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= {WIDTH{1'b0}};
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            eq       <= 1'b0;
            gt       <= 1'b0;
            lt       <= 1'b0;
            illegal  <= 1'b0;
`ifdef EXEC_MULDIV_EN
            hi_out   <= {WIDTH{1'b0}};
            div_zero <= 1'b0;
`endif
        end else begin
            busy <= (state_s == ST_SHIFT) || (state_s == ST_MUL) || (state_s == ST_DIV);
            done <= (state_s == ST_DONE);
            if (state_s == ST_DONE) begin
                result   <= fin_res_s;
                overflow <= fin_ovf_s;
                zero     <= (fin_res_s == {WIDTH{1'b0}});
                negative <= fin_res_s[WIDTH-1];
                eq       <= fin_eq_s;
                gt       <= fin_gt_s;
                lt       <= fin_lt_s;
                illegal  <= fin_ill_s;
`ifdef EXEC_MULDIV_EN
                div_zero <= fin_dz_s;
                if (fin_hi_we_s) begin
                    hi_out <= fin_hi_s;
                end
`endif
            end
        end
    end

`ifndef EXEC_MULDIV_EN
    assign hi_out   = {WIDTH{1'b0}};
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed cases plus random ops against an arithmetic reference model.
module tb_exec_unit;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic        clk = 1'b0;
    logic        rst_n, start, shamt_sel;
    logic [3:0]  op;
    logic [31:0] src_a, src_b;
    logic [4:0]  shamt;
    logic        busy, done, overflow, zero, negative, eq, gt, lt, div_zero, illegal;
    logic [31:0] result, hi_out;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] exp_res, exp_hi;
    logic        exp_ovf, exp_eq, exp_gt, exp_lt, exp_dz, exp_ill;
    int          exp_lat;

    exec_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk(clk), .reset(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .shamt(shamt), .shamt_sel(shamt_sel), .busy(busy), .done(done), .result(result),
        .hi_out(hi_out), .overflow(overflow), .zero(zero), .negative(negative), .eq(eq),
        .gt(gt), .lt(lt), .div_zero(div_zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference behaviour from plain signed/unsigned arithmetic
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic sel);
        longint sa, sb, s, p, q, r;
        int     n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        exp_res = 32'd0; exp_ovf = 1'b0; exp_dz = 1'b0; exp_ill = 1'b0; exp_lat = 1;
        exp_eq = (a == b); exp_gt = (sa > sb); exp_lt = (sa < sb);
        n = sel ? int'(b[4:0]) : int'(sh);
        case (o)
            4'd0: exp_res = a;
            4'd1: begin s = sa + sb; exp_res = s[31:0]; exp_ovf = (s != longint'($signed(exp_res))); end
            4'd2: begin s = sa - sb; exp_res = s[31:0]; exp_ovf = (s != longint'($signed(exp_res))); end
            4'd3: exp_res = a & b;
            4'd4: exp_res = a | b;
            4'd5: exp_res = a ^ b;
            4'd6: exp_res = ~a;
            4'd7: begin s = sa + 64'sd1; exp_res = s[31:0]; exp_ovf = (s != longint'($signed(exp_res))); end
            4'd8, 4'd9, 4'd10, 4'd11: begin
                if (o == 4'd8)       exp_res = a << n;
                else if (o == 4'd9)  exp_res = a >> n;
                else if (o == 4'd10) exp_res = $signed(a) >>> n;
                else                 exp_res = (a >> n) | (a << (32 - n));
                exp_lat = (n == 0) ? 1 : n + 1;
            end
`ifdef EXEC_MULDIV_EN
            4'd12: begin p = sa * sb; exp_res = p[31:0]; exp_hi = p[63:32]; exp_lat = 33; end
            4'd13: begin
                if (b == 32'd0) begin
                    exp_dz = 1'b1;
                end else begin
                    q = sa / sb; r = sa % sb;
                    exp_res = q[31:0]; exp_hi = r[31:0]; exp_lat = 33;
                end
            end
`endif
            default: exp_ill = 1'b1;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic sel,
                          input bit poke, input bit b2b);
        int cyc, busy_cyc;
        model(o, a, b, sh, sel);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; shamt = sh; shamt_sel = sel;
        @(posedge clk); #1;
        start = 1'b0; op = 4'($urandom); src_a = $urandom; src_b = $urandom; shamt = 5'($urandom);
        cyc = 1; busy_cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) busy_cyc++;
            if (poke && cyc == 2) begin start = 1'b1; op = 4'd1; end
            else start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " busy_cycles"}, 64'(busy_cyc), 64'(exp_lat - 1));
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check({tag, " result"}, 64'(result), 64'(exp_res));
        check({tag, " hi_out"}, 64'(hi_out), 64'(exp_hi));
        check({tag, " flags"}, 64'({overflow, zero, negative, eq, gt, lt, div_zero, illegal}),
              64'({exp_ovf, exp_res == 32'd0, exp_res[31], exp_eq, exp_gt, exp_lt, exp_dz, exp_ill}));
        if (!b2b) begin
            @(posedge clk); #1;
            check({tag, " done_pulse"}, 64'(done), 64'd0);
            check({tag, " result_hold"}, 64'(result), 64'(exp_res));
            check({tag, " hi_hold"}, 64'(hi_out), 64'(exp_hi));
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 4'd0; src_a = 32'd0; src_b = 32'd0;
        shamt = 5'd0; shamt_sel = 1'b0; exp_hi = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ctrl", 64'({busy, done}), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset hi", 64'(hi_out), 64'd0);
        check("reset flags", 64'({overflow, zero, negative, eq, gt, lt, div_zero, illegal}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_ovf", 4'd1, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b0, 1'b0, 1'b0);
        run_op("sra_b4", 4'd10, 32'hF000_0000, 32'd4, 5'd0, 1'b1, 1'b0, 1'b0);
        run_op("sra_n0", 4'd10, 32'hF000_0000, 32'd4, 5'd0, 1'b0, 1'b0, 1'b0);
        run_op("ror_n1", 4'd11, 32'h0000_0003, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        run_op("sll_poke", 4'd8, 32'h0000_00A5, 32'd3, 5'd10, 1'b0, 1'b1, 1'b0);
        run_op("b2b_first", 4'd5, 32'h1234_5678, 32'h0F0F_0F0F, 5'd0, 1'b0, 1'b0, 1'b1);
        run_op("b2b_alu", 4'd2, 32'h8000_0000, 32'h0000_0001, 5'd0, 1'b0, 1'b0, 1'b1);
        run_op("b2b_shift", 4'd9, 32'h8000_0001, 32'd0, 5'd3, 1'b0, 1'b0, 1'b0);
        run_op("op14", 4'd14, 32'h1111_1111, 32'h2222_2222, 5'd0, 1'b0, 1'b0, 1'b0);
        run_op("op12", 4'd12, 32'hFFFF_FFFD, 32'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        run_op("op13", 4'd13, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        run_op("div0", 4'd13, 32'h0000_0009, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // reset in the middle of a long shift
        @(negedge clk);
        start = 1'b1; op = 4'd8; src_a = 32'hDEAD_BEEF; shamt = 5'd20; shamt_sel = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("midshift busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort ctrl", 64'({busy, done}), 64'd0);
        check("abort result", 64'(result), 64'd0);
        check("abort hi", 64'(hi_out), 64'd0);
        check("abort flags", 64'({overflow, zero, negative, eq, gt, lt, div_zero, illegal}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_hi = 32'd0;
        run_op("post_reset", 4'd7, 32'h7FFF_FFFF, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 250; i++) begin
            run_op("rand", 4'($urandom_range(0, 15)), pick(), pick(), 5'($urandom),
                   1'($urandom), 1'b0, ($urandom_range(0, 3) == 0));
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
